// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port count, port indices and the
// dimension-ordered XY routing decision.
package noc_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PORT_IDX_W = 3;

    typedef enum logic [PORT_IDX_W-1:0] {
        PORT_N  = 3'd0,
        PORT_S  = 3'd1,
        PORT_E  = 3'd2,
        PORT_W  = 3'd3,
        PORT_PE = 3'd4
    } port_e;

    // Coordinates arrive zero-extended to 32 bits so any field width up to 32 works.
    function automatic port_e route_port(input logic [31:0] dst_x,
                                         input logic [31:0] dst_y,
                                         input logic [31:0] my_x,
                                         input logic [31:0] my_y);
        port_e dir;
        if (dst_x > my_x) begin
            dir = PORT_E;
        end else if (dst_x < my_x) begin
            dir = PORT_W;
        end else if (dst_y > my_y) begin
            dir = PORT_N;
        end else if (dst_y < my_y) begin
            dir = PORT_S;
        end else begin
            dir = PORT_PE;
        end
        return dir;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Input buffer for one router port: power-of-two depth, pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_mesh_router.sv
// Five-port mesh router node: per-input FIFOs, XY routing of each FIFO head,
// and a round-robin arbiter feeding a one-flit register slot on every output.
module noc_mesh_router
    import noc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_PORTS-1:0]                       in_valid,
    output logic [NUM_PORTS-1:0]                       in_ready,
    input  logic [NUM_PORTS-1:0][X_W+Y_W+DATA_W-1:0]   in_flit,
    output logic [NUM_PORTS-1:0]                       out_valid,
    input  logic [NUM_PORTS-1:0]                       out_ready,
    output logic [NUM_PORTS-1:0][X_W+Y_W+DATA_W-1:0]   out_flit
);

    localparam int FLIT_W = X_W + Y_W + DATA_W;

    logic [NUM_PORTS-1:0]                  fifo_full;
    logic [NUM_PORTS-1:0]                  fifo_empty;
    logic [NUM_PORTS-1:0]                  fifo_push;
    logic [NUM_PORTS-1:0]                  fifo_pop;
    logic [NUM_PORTS-1:0][FLIT_W-1:0]      fifo_head;
    port_e                                 head_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]                  grant_valid;
    logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]  grant_idx;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        logic pop_any;

        // Reset forces in_ready low so nothing is accepted while buffers clear.
        assign in_ready[i]  = !fifo_full[i] && !reset;
        assign fifo_push[i] = in_valid[i] && in_ready[i];

        noc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[i]),
            .push_data (in_flit[i]),
            .pop       (fifo_pop[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .head      (fifo_head[i])
        );

        assign head_dest[i] = route_port(32'(fifo_head[i][FLIT_W-1 -: X_W]),
                                         32'(fifo_head[i][DATA_W +: Y_W]),
                                         32'(MY_X), 32'(MY_Y));

        always_comb begin
            pop_any = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant_valid[o] && (grant_idx[o] == PORT_IDX_W'(i))) begin
                    pop_any = 1'b1;
                end
            end
        end

        assign fifo_pop[i] = pop_any;
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0]  req;
        logic [PORT_IDX_W-1:0] rr_ptr;
        logic [PORT_IDX_W:0]   cand;
        logic                  gv;
        logic [PORT_IDX_W-1:0] gi;
        logic                  can_load;
        logic                  slot_valid;
        logic [FLIT_W-1:0]     slot_flit;

        assign can_load = !slot_valid || out_ready[o];

        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = !fifo_empty[i] && (head_dest[i] == port_e'(PORT_IDX_W'(o)));
            end
        end

        // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
        always_comb begin
            gv   = 1'b0;
            gi   = '0;
            cand = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = {1'b0, rr_ptr} + (PORT_IDX_W+1)'(k);
                if (cand >= (PORT_IDX_W+1)'(NUM_PORTS)) begin
                    cand = cand - (PORT_IDX_W+1)'(NUM_PORTS);
                end
                if (!gv && can_load && req[cand[PORT_IDX_W-1:0]]) begin
                    gv = 1'b1;
                    gi = cand[PORT_IDX_W-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_valid <= 1'b0;
                slot_flit  <= '0;
                rr_ptr     <= '0;
            end else if (gv) begin
                slot_valid <= 1'b1;
                slot_flit  <= fifo_head[gi];
                rr_ptr     <= (gi == PORT_IDX_W'(NUM_PORTS-1)) ? '0 : gi + 1'b1;
            end else if (out_ready[o]) begin
                slot_valid <= 1'b0;
            end
        end

        assign out_valid[o]   = slot_valid;
        assign out_flit[o]    = slot_flit;
        assign grant_valid[o] = gv;
        assign grant_idx[o]   = gi;
    end

endmodule

// File: tb/tb_noc_mesh_router.sv
// Self-checking bench for noc_mesh_router at node (1,1): directed scenarios with
// literal expectations, then randomized traffic checked against a queue model.
module tb_noc_mesh_router;

    localparam int NP    = 5;
    localparam int FW    = 12;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NP-1:0]       in_valid;
    logic [NP-1:0]       in_ready;
    logic [NP-1:0][FW-1:0] in_flit;
    logic [NP-1:0]       out_valid;
    logic [NP-1:0]       out_ready;
    logic [NP-1:0][FW-1:0] out_flit;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain queues per input, one slot per output, rr pointers.
    logic [FW-1:0] mq [NP][$];
    bit   [NP-1:0] m_valid;
    logic [FW-1:0] m_flit [NP];
    int            m_ptr [NP];
    logic [NP-1:0] dut_acc;

    noc_mesh_router #(
        .DATA_W     (8),
        .X_W        (2),
        .Y_W        (2),
        .MY_X       (1),
        .MY_Y       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // XY rule for node (1,1): 0=N 1=S 2=E 3=W 4=PE
    function automatic int model_route(logic [FW-1:0] f);
        int dx = int'(f[11:10]);
        int dy = int'(f[9:8]);
        if (dx > 1) return 2;
        if (dx < 1) return 3;
        if (dy > 1) return 0;
        if (dy < 1) return 1;
        return 4;
    endfunction

    task automatic model_step();
        int            g [NP];
        bit   [NP-1:0] rdy;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                m_flit[p] = '0;
                m_ptr[p]  = 0;
            end
            m_valid = '0;
            return;
        end
        for (int p = 0; p < NP; p++) rdy[p] = (mq[p].size() < DEPTH);
        for (int o = 0; o < NP; o++) begin
            g[o] = -1;
            if (!m_valid[o] || out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    int i = (m_ptr[o] + k) % NP;
                    if (g[o] < 0 && mq[i].size() > 0 && model_route(mq[i][0]) == o) g[o] = i;
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (g[o] >= 0) begin
                m_flit[o]  = mq[g[o]].pop_front();
                m_valid[o] = 1'b1;
                m_ptr[o]   = (g[o] + 1) % NP;
            end else if (out_ready[o]) begin
                m_valid[o] = 1'b0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && rdy[p]) mq[p].push_back(in_flit[p]);
        end
    endtask

    task automatic applyStimulus(input logic [NP-1:0] v, input logic [NP-1:0][FW-1:0] f,
                                 input logic [NP-1:0] r);
        in_valid  = v;
        in_flit   = f;
        out_ready = r;
    endtask

    task automatic checkOutput();
        for (int o = 0; o < NP; o++) begin
            check($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(m_valid[o]));
            check($sformatf("out_flit[%0d]", o), 32'(out_flit[o]), 32'(m_flit[o]));
        end
    endtask

    task automatic cycle();
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("in_ready[%0d]", p), 32'(in_ready[p]),
                  32'(!reset && mq[p].size() < DEPTH));
        end
        dut_acc = in_valid & in_ready;
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [NP-1:0][FW-1:0] f;
        logic [FW-1:0]         got [$];
        int                    n;
        int                    acc_cnt;

        f = '0;
        reset = 1'b1;
        applyStimulus('0, f, '1);
        repeat (2) cycle();
        check("reset out_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;

        // PE -> E with single-cycle hop through the switch
        f = '0; f[4] = 12'hDA5;
        applyStimulus(5'b10000, f, '1);
        cycle();
        applyStimulus('0, f, '1);
        cycle();
        check("pe_to_e valid", 32'(out_valid), 32'h04);
        check("pe_to_e flit", 32'(out_flit[2]), 32'hDA5);
        cycle();

        // N -> PE and S -> S in parallel
        f = '0; f[0] = 12'h53C; f[1] = 12'h477;
        applyStimulus(5'b00011, f, '1);
        cycle();
        applyStimulus('0, f, '1);
        cycle();
        check("parallel valid", 32'(out_valid), 32'h12);
        check("parallel pe flit", 32'(out_flit[4]), 32'h53C);
        check("parallel s flit", 32'(out_flit[1]), 32'h477);
        cycle();

        // Three inputs contend for E
        f = '0; f[0] = 12'h911; f[1] = 12'h922; f[3] = 12'h933;
        applyStimulus(5'b01011, f, '1);
        cycle();
        applyStimulus('0, f, '1);
        cycle(); check("rr first", 32'(out_flit[2]), 32'h911);
        cycle(); check("rr second", 32'(out_flit[2]), 32'h922);
        cycle(); check("rr third", 32'(out_flit[2]), 32'h933);
        f = '0; f[0] = 12'h955; f[4] = 12'h944;
        applyStimulus(5'b10001, f, '1);
        cycle();
        applyStimulus('0, f, '1);
        cycle(); check("rr ptr4 pe", 32'(out_flit[2]), 32'h944);
        cycle(); check("rr ptr4 n", 32'(out_flit[2]), 32'h955);
        cycle();

        // Back-pressure on E: path capacity is FIFO depth plus the slot
        n = 1; acc_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            f = '0; f[4] = 12'h900 + 12'(n);
            applyStimulus(5'b10000, f, 5'b11011);
            cycle();
            if (dut_acc[4]) begin acc_cnt++; n++; end
        end
        check("stall accepted", 32'(acc_cnt), 32'd5);
        check("stall in_ready", 32'(in_ready[4]), 32'h0);
        check("stall held flit", 32'(out_flit[2]), 32'h901);
        for (int c = 0; c < 6; c++) begin
            f = '0; f[4] = 12'h900 + 12'(n);
            applyStimulus((n <= 6) ? 5'b10000 : 5'b00000, f, '1);
            cycle();
            if (dut_acc[4]) n++;
            if (out_valid[2]) got.push_back(out_flit[2]);
        end
        check("drain count", 32'(got.size()), 32'd5);
        for (int k = 0; k < got.size() && k < 5; k++) begin
            check($sformatf("drain order %0d", k), 32'(got[k]), 32'h902 + 32'(k));
        end

        // Fill FIFOs, then reset mid-traffic
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < NP; p++) f[p] = 12'($urandom);
            applyStimulus('1, f, '0);
            cycle();
        end
        reset = 1'b1;
        #1;
        check("in_ready during reset", 32'(in_ready), 32'h0);
        cycle();
        check("post-reset out_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        applyStimulus('0, f, '1);
        #1;
        check("in_ready after reset", 32'(in_ready), 32'h1F);
        f = '0; f[0] = 12'h9A1; f[4] = 12'h9A2;
        applyStimulus(5'b10001, f, '1);
        cycle();
        applyStimulus('0, f, '1);
        cycle(); check("ptr0 after reset n", 32'(out_flit[2]), 32'h9A1);
        cycle(); check("ptr0 after reset pe", 32'(out_flit[2]), 32'h9A2);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            logic [NP-1:0] r;
            for (int p = 0; p < NP; p++) begin
                f[p] = 12'($urandom);
                r[p] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus(5'($urandom), f, r);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
